// File: rtl/ps2_ascii_decoder.sv
// Purpose : PS/2 Set-2 scan-code bytes -> ASCII characters, buffered in a FWFT FIFO.
// Latency : 1 cycle from a mapped scan_valid strobe to ascii_valid/ascii_code when the FIFO is empty.
// Backpr. : ascii_valid/ascii_ready handshake; a push into a full FIFO without a pop is dropped and flagged on overflow.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   scan_code/_valid scan-code byte with single-cycle strobe from the PS/2 receiver
//   ascii_code/_valid/_ready  FIFO head toward the keyboard I/O port (code is 00 when empty)
//   fifo_count      number of stored characters
//   overflow        one-cycle pulse, registered, after a character was dropped
//   caps_lock       Caps Lock state; shift_active = left or right Shift held
module ps2_ascii_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CASE_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    scan_code,
  input  logic                          scan_valid,
  output logic [7:0]                    ascii_code,
  output logic                          ascii_valid,
  input  logic                          ascii_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          caps_lock,
  output logic                          shift_active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  logic [1:0]    state_q;
  logic          shift_l_q, shift_r_q;
  logic          caps_q, caps_held_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  // ---------------- character map ----------------
  logic       letter_hit, digit_hit;
  logic [4:0] letter_idx;
  logic [3:0] digit_idx;

  always_comb begin
    letter_hit = 1'b0;
    letter_idx = 5'd0;
    digit_hit  = 1'b0;
    digit_idx  = 4'd0;
    case (scan_code)
      8'h45: {digit_hit, digit_idx} = {1'b1, 4'd0};
      8'h16: {digit_hit, digit_idx} = {1'b1, 4'd1};
      8'h1E: {digit_hit, digit_idx} = {1'b1, 4'd2};
      8'h26: {digit_hit, digit_idx} = {1'b1, 4'd3};
      8'h25: {digit_hit, digit_idx} = {1'b1, 4'd4};
      8'h2E: {digit_hit, digit_idx} = {1'b1, 4'd5};
      8'h36: {digit_hit, digit_idx} = {1'b1, 4'd6};
      8'h3D: {digit_hit, digit_idx} = {1'b1, 4'd7};
      8'h3E: {digit_hit, digit_idx} = {1'b1, 4'd8};
      8'h46: {digit_hit, digit_idx} = {1'b1, 4'd9};
      8'h1C: {letter_hit, letter_idx} = {1'b1, 5'd0};
      8'h32: {letter_hit, letter_idx} = {1'b1, 5'd1};
      8'h21: {letter_hit, letter_idx} = {1'b1, 5'd2};
      8'h23: {letter_hit, letter_idx} = {1'b1, 5'd3};
      8'h24: {letter_hit, letter_idx} = {1'b1, 5'd4};
      8'h2B: {letter_hit, letter_idx} = {1'b1, 5'd5};
      8'h34: {letter_hit, letter_idx} = {1'b1, 5'd6};
      8'h33: {letter_hit, letter_idx} = {1'b1, 5'd7};
      8'h43: {letter_hit, letter_idx} = {1'b1, 5'd8};
      8'h3B: {letter_hit, letter_idx} = {1'b1, 5'd9};
      8'h42: {letter_hit, letter_idx} = {1'b1, 5'd10};
      8'h4B: {letter_hit, letter_idx} = {1'b1, 5'd11};
      8'h3A: {letter_hit, letter_idx} = {1'b1, 5'd12};
      8'h31: {letter_hit, letter_idx} = {1'b1, 5'd13};
      8'h44: {letter_hit, letter_idx} = {1'b1, 5'd14};
      8'h4D: {letter_hit, letter_idx} = {1'b1, 5'd15};
      8'h15: {letter_hit, letter_idx} = {1'b1, 5'd16};
      8'h2D: {letter_hit, letter_idx} = {1'b1, 5'd17};
      8'h1B: {letter_hit, letter_idx} = {1'b1, 5'd18};
      8'h2C: {letter_hit, letter_idx} = {1'b1, 5'd19};
      8'h3C: {letter_hit, letter_idx} = {1'b1, 5'd20};
      8'h2A: {letter_hit, letter_idx} = {1'b1, 5'd21};
      8'h1D: {letter_hit, letter_idx} = {1'b1, 5'd22};
      8'h22: {letter_hit, letter_idx} = {1'b1, 5'd23};
      8'h35: {letter_hit, letter_idx} = {1'b1, 5'd24};
      8'h1A: {letter_hit, letter_idx} = {1'b1, 5'd25};
      default: ;
    endcase
  end

  logic [7:0] shifted_sym;

  always_comb begin
    case (digit_idx)
      4'd0:    shifted_sym = 8'h29;  // )
      4'd1:    shifted_sym = 8'h21;  // !
      4'd2:    shifted_sym = 8'h40;  // @
      4'd3:    shifted_sym = 8'h23;  // #
      4'd4:    shifted_sym = 8'h24;  // $
      4'd5:    shifted_sym = 8'h25;  // %
      4'd6:    shifted_sym = 8'h5E;  // ^
      4'd7:    shifted_sym = 8'h26;  // &
      4'd8:    shifted_sym = 8'h2A;  // *
      default: shifted_sym = 8'h28;  // (
    endcase
  end

  // Shift/Caps used here are the registered values, i.e. state before this byte.
  logic       upper;
  logic       map_hit;
  logic [7:0] map_dat;

  always_comb begin
    upper   = (CASE_MODE != 0) || (shift_active ^ caps_q);
    map_hit = 1'b1;
    map_dat = 8'h00;
    if (letter_hit) begin
      map_dat = (upper ? 8'h41 : 8'h61) + {3'b000, letter_idx};
    end else if (digit_hit) begin
      map_dat = shift_active ? shifted_sym : (8'h30 + {4'b0000, digit_idx});
    end else begin
      case (scan_code)
        8'h29:   map_dat = 8'h20;
        8'h5A:   map_dat = 8'h0D;
        8'h66:   map_dat = 8'h08;
        default: map_hit = 1'b0;
      endcase
    end
  end

  // Prefix/modifier codes are not in the map, so map_hit alone qualifies IDLE pushes.
  // Keypad Enter (E0 5A) reuses the 5A map entry, which is already 0D.
  logic push_vld;

  assign push_vld = scan_valid &&
                    (((state_q == ST_IDLE) && map_hit) ||
                     ((state_q == ST_EXT) && (scan_code == 8'h5A)));

  // ---------------- prefix FSM and modifiers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          case (scan_code)
            8'hF0: state_q   <= ST_BRK;
            8'hE0: state_q   <= ST_EXT;
            8'h12: shift_l_q <= 1'b1;
            8'h59: shift_r_q <= 1'b1;
            8'h58: begin
              // Typematic repeats of a held Caps Lock must not re-toggle.
              if (!caps_held_q) begin
                caps_q      <= ~caps_q;
                caps_held_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_BRK: begin
          case (scan_code)
            8'h12:   shift_l_q   <= 1'b0;
            8'h59:   shift_r_q   <= 1'b0;
            8'h58:   caps_held_q <= 1'b0;
            default: ;
          endcase
          state_q <= ST_IDLE;
        end
        ST_EXT:  state_q <= (scan_code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic fifo_full, do_pop, do_wr, do_drop;

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign do_pop    = (count_q != '0) && ascii_ready;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
  assign do_wr     = push_vld && (!fifo_full || do_pop);
  assign do_drop   = push_vld && fifo_full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= map_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= do_drop;
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_wr, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign ascii_valid  = (count_q != '0);
  assign ascii_code   = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;
  assign caps_lock    = caps_q;
  assign shift_active = shift_l_q | shift_r_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
module tb_ps2_ascii_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       ascii_ready = 1'b0;
  logic [7:0] ascii_code;
  logic       ascii_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       caps_lock;
  logic       shift_active;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_ascii_decoder #(.FIFO_DEPTH(4), .CASE_MODE(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .ascii_code   (ascii_code),
    .ascii_valid  (ascii_valid),
    .ascii_ready  (ascii_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .caps_lock    (caps_lock),
    .shift_active (shift_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached (checks=%0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs applied before the rising edge, outputs settle for sampling at the falling edge.
  task automatic cyc(input logic sv, input logic [7:0] code, input logic rdy);
    scan_valid  = sv;
    scan_code   = code;
    ascii_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    scan_valid  = 1'b0;
    scan_code   = 8'h00;
    ascii_ready = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] digit_syms  [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};

  bit         m_lshift, m_rshift, m_caps, m_held, m_f0, m_e0, m_ovf;
  logic [7:0] m_q [$];

  function automatic logic [8:0] lookup(input logic [7:0] c, input bit sh, input bit cp);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return {1'b1, ((sh ^ cp) ? 8'd65 : 8'd97) + 8'(i)};
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return {1'b1, sh ? digit_syms[i] : 8'd48 + 8'(i)};
    if (c == 8'h29) return {1'b1, 8'h20};
    if (c == 8'h5A) return {1'b1, 8'h0D};
    if (c == 8'h66) return {1'b1, 8'h08};
    return 9'h000;
  endfunction

  task automatic model_reset();
    m_lshift = 0; m_rshift = 0; m_caps = 0; m_held = 0;
    m_f0 = 0; m_e0 = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit sv, input logic [7:0] c, input bit rdy);
    bit         pop, push;
    logic [7:0] ch;
    logic [8:0] lk;
    int         pre;
    pre   = m_q.size();
    pop   = rdy && (pre > 0);
    push  = 0;
    ch    = 8'h00;
    m_ovf = 0;
    if (sv) begin
      if (m_e0 && m_f0) begin
        m_e0 = 0; m_f0 = 0;
      end else if (m_e0) begin
        if (c == 8'hF0) m_f0 = 1;
        else begin
          if (c == 8'h5A) begin push = 1; ch = 8'h0D; end
          m_e0 = 0;
        end
      end else if (m_f0) begin
        if (c == 8'h12) m_lshift = 0;
        if (c == 8'h59) m_rshift = 0;
        if (c == 8'h58) m_held = 0;
        m_f0 = 0;
      end else begin
        if (c == 8'hF0) m_f0 = 1;
        else if (c == 8'hE0) m_e0 = 1;
        else if (c == 8'h12) m_lshift = 1;
        else if (c == 8'h59) m_rshift = 1;
        else if (c == 8'h58) begin
          if (!m_held) begin m_caps = !m_caps; m_held = 1; end
        end else begin
          lk = lookup(c, m_lshift | m_rshift, m_caps);
          push = lk[8];
          ch = lk[7:0];
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (pre < 4 || pop) m_q.push_back(ch);
      else m_ovf = 1;
    end
  endtask

  task automatic model_check(input int n);
    chk($sformatf("rnd%0d.valid", n), 32'(ascii_valid), 32'(m_q.size() != 0));
    chk($sformatf("rnd%0d.code", n), 32'(ascii_code), 32'((m_q.size() != 0) ? m_q[0] : 8'h00));
    chk($sformatf("rnd%0d.count", n), 32'(fifo_count), 32'(m_q.size()));
    chk($sformatf("rnd%0d.caps", n), 32'(caps_lock), 32'(m_caps));
    chk($sformatf("rnd%0d.shift", n), 32'(shift_active), 32'(m_lshift | m_rshift));
    chk($sformatf("rnd%0d.ovf", n), 32'(overflow), 32'(m_ovf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       sv;
    logic [7:0] code;
    logic       rdy;
    logic       ev;
    logic [7:0] ec;
    logic [2:0] ecnt;
    logic       ecaps;
    logic       esh;
  } vec_t;

  vec_t vecs [$];

  task automatic v(input logic sv, input logic [7:0] code, input logic rdy, input logic ev,
                   input logic [7:0] ec, input logic [2:0] ecnt, input logic ecaps, input logic esh);
    vec_t r;
    r.sv = sv; r.code = code; r.rdy = rdy; r.ev = ev;
    r.ec = ec; r.ecnt = ecnt; r.ecaps = ecaps; r.esh = esh;
    vecs.push_back(r);
  endtask

  initial begin
    logic [8:0] popped [$];
    logic [7:0] exp_drain [8];
    int         ovf_cnt;
    int         guard;
    logic [7:0] pool [20];
    logic       r_sv, r_rdy;
    logic [7:0] r_code;

    // make/break, single letters
    v(1,8'h1C,0, 1,8'h61,1,0,0);
    v(1,8'hF0,0, 1,8'h61,1,0,0);
    v(1,8'h1C,0, 1,8'h61,1,0,0);
    v(0,8'h00,1, 0,8'h00,0,0,0);
    // shift / shifted digit / caps
    v(1,8'h12,0, 0,8'h00,0,0,1);
    v(1,8'h1C,0, 1,8'h41,1,0,1);
    v(1,8'hF0,0, 1,8'h41,1,0,1);
    v(1,8'h12,0, 1,8'h41,1,0,0);
    v(1,8'h1C,0, 1,8'h41,2,0,0);
    v(0,8'h00,1, 1,8'h61,1,0,0);
    v(0,8'h00,1, 0,8'h00,0,0,0);
    v(1,8'h12,0, 0,8'h00,0,0,1);
    v(1,8'h16,0, 1,8'h21,1,0,1);
    v(1,8'hF0,0, 1,8'h21,1,0,1);
    v(1,8'h12,0, 1,8'h21,1,0,0);
    v(0,8'h00,1, 0,8'h00,0,0,0);
    v(1,8'h58,0, 0,8'h00,0,1,0);
    v(1,8'hF0,0, 0,8'h00,0,1,0);
    v(1,8'h58,0, 0,8'h00,0,1,0);
    v(1,8'h1C,0, 1,8'h41,1,1,0);
    v(1,8'h59,0, 1,8'h41,1,1,1);
    v(1,8'h1C,0, 1,8'h41,2,1,1);
    v(0,8'h00,1, 1,8'h61,1,1,1);
    v(1,8'hF0,1, 0,8'h00,0,1,1);
    v(1,8'h59,0, 0,8'h00,0,1,0);
    // caps back off, then typematic sequence
    v(1,8'h58,0, 0,8'h00,0,0,0);
    v(1,8'hF0,0, 0,8'h00,0,0,0);
    v(1,8'h58,0, 0,8'h00,0,0,0);
    v(1,8'h58,0, 0,8'h00,0,1,0);
    v(1,8'h58,0, 0,8'h00,0,1,0);
    v(1,8'h58,0, 0,8'h00,0,1,0);
    v(1,8'hF0,0, 0,8'h00,0,1,0);
    v(1,8'h58,0, 0,8'h00,0,1,0);
    v(1,8'h58,0, 0,8'h00,0,0,0);
    v(1,8'hF0,0, 0,8'h00,0,0,0);
    v(1,8'h58,0, 0,8'h00,0,0,0);
    // extended prefix
    v(1,8'hE0,0, 0,8'h00,0,0,0);
    v(1,8'h5A,0, 1,8'h0D,1,0,0);
    v(1,8'hE0,0, 1,8'h0D,1,0,0);
    v(1,8'hF0,0, 1,8'h0D,1,0,0);
    v(1,8'h5A,0, 1,8'h0D,1,0,0);
    v(1,8'h29,0, 1,8'h0D,2,0,0);
    v(0,8'h00,1, 1,8'h20,1,0,0);
    v(0,8'h00,1, 0,8'h00,0,0,0);
    // specials ignore shift; shifted 0 is ')'
    v(1,8'h12,0, 0,8'h00,0,0,1);
    v(1,8'h29,0, 1,8'h20,1,0,1);
    v(1,8'h5A,0, 1,8'h20,2,0,1);
    v(1,8'h66,0, 1,8'h20,3,0,1);
    v(1,8'h45,0, 1,8'h20,4,0,1);
    v(1,8'hF0,0, 1,8'h20,4,0,1);
    v(1,8'h12,0, 1,8'h20,4,0,0);
    v(0,8'h00,1, 1,8'h0D,3,0,0);
    v(0,8'h00,1, 1,8'h08,2,0,0);
    v(0,8'h00,1, 1,8'h29,1,0,0);
    v(0,8'h00,1, 0,8'h00,0,0,0);
    // unmapped codes, E0+other, non-strobed code
    v(1,8'h76,0, 0,8'h00,0,0,0);
    v(1,8'hE0,0, 0,8'h00,0,0,0);
    v(1,8'h76,0, 0,8'h00,0,0,0);
    v(1,8'h3D,0, 1,8'h37,1,0,0);
    v(0,8'h00,1, 0,8'h00,0,0,0);
    v(0,8'h1C,0, 0,8'h00,0,0,0);

    // reset state
    repeat (2) @(negedge clk);
    chk("reset.valid", 32'(ascii_valid), 32'd0);
    chk("reset.code", 32'(ascii_code), 32'h00);
    chk("reset.count", 32'(fifo_count), 32'd0);
    chk("reset.ovf", 32'(overflow), 32'd0);
    chk("reset.caps", 32'(caps_lock), 32'd0);
    chk("reset.shift", 32'(shift_active), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      cyc(vecs[i].sv, vecs[i].code, vecs[i].rdy);
      chk($sformatf("vec%0d.valid", i), 32'(ascii_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d.code", i), 32'(ascii_code), 32'(vecs[i].ec));
      chk($sformatf("vec%0d.count", i), 32'(fifo_count), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d.caps", i), 32'(caps_lock), 32'(vecs[i].ecaps));
      chk($sformatf("vec%0d.shift", i), 32'(shift_active), 32'(vecs[i].esh));
      chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'd0);
    end

    // FIFO full / overflow / simultaneous push+pop across pointer wrap
    do_reset();
    ovf_cnt = 0;
    cyc(1,8'h1C,0); if (overflow) ovf_cnt++;
    cyc(1,8'h32,0); if (overflow) ovf_cnt++;
    cyc(1,8'h21,0); if (overflow) ovf_cnt++;
    cyc(1,8'h23,0); if (overflow) ovf_cnt++;
    chk("full.count", 32'(fifo_count), 32'd4);
    cyc(1,8'h24,0); if (overflow) ovf_cnt++;
    cyc(0,8'h00,0); if (overflow) ovf_cnt++;
    cyc(0,8'h00,0); if (overflow) ovf_cnt++;
    chk("full.ovf_pulses", 32'(ovf_cnt), 32'd1);
    chk("full.count_after", 32'(fifo_count), 32'd4);
    chk("full.head", 32'(ascii_code), 32'h61);
    foreach (exp_drain[i]) exp_drain[i] = 8'h00;
    exp_drain[0] = 8'h61; exp_drain[1] = 8'h62; exp_drain[2] = 8'h63; exp_drain[3] = 8'h64;
    exp_drain[4] = 8'h66; exp_drain[5] = 8'h67; exp_drain[6] = 8'h68; exp_drain[7] = 8'h69;
    pool[0] = 8'h2B; pool[1] = 8'h34; pool[2] = 8'h33; pool[3] = 8'h43;
    for (int i = 0; i < 4; i++) begin
      if (ascii_valid) popped.push_back({1'b0, ascii_code});
      cyc(1, pool[i], 1);
      chk($sformatf("pushpop%0d.count", i), 32'(fifo_count), 32'd4);
      chk($sformatf("pushpop%0d.ovf", i), 32'(overflow), 32'd0);
    end
    guard = 0;
    while (ascii_valid && guard < 20) begin
      popped.push_back({1'b0, ascii_code});
      cyc(0, 8'h00, 1);
      guard++;
    end
    chk("drain.len", 32'(popped.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("drain%0d", i), 32'((i < popped.size()) ? popped[i] : 9'h100), 32'(exp_drain[i]));
    chk("drain.empty_code", 32'(ascii_code), 32'h00);
    chk("drain.empty_ready", 32'(fifo_count), 32'd0);

    // asynchronous reset in the middle of a break sequence
    do_reset();
    cyc(1,8'h58,0);
    cyc(1,8'h1C,0);
    cyc(1,8'h32,0);
    cyc(1,8'hF0,0);
    chk("midrst.pre_count", 32'(fifo_count), 32'd2);
    chk("midrst.pre_head", 32'(ascii_code), 32'h41);
    chk("midrst.pre_caps", 32'(caps_lock), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(ascii_valid), 32'd0);
    chk("midrst.count", 32'(fifo_count), 32'd0);
    chk("midrst.caps", 32'(caps_lock), 32'd0);
    chk("midrst.code", 32'(ascii_code), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1,8'h1C,0);
    chk("midrst.after_valid", 32'(ascii_valid), 32'd1);
    chk("midrst.after_code", 32'(ascii_code), 32'h61);
    chk("midrst.after_count", 32'(fifo_count), 32'd1);

    // randomized traffic against the model
    do_reset();
    pool = '{8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h32, 8'h45, 8'h16, 8'h3D,
             8'h29, 8'h5A, 8'h66, 8'h76, 8'hF0, 8'h12, 8'h59, 8'h58, 8'h2B, 8'h1A};
    for (int n = 0; n < 3000; n++) begin
      r_sv   = ($urandom_range(0, 9) < 7);
      r_code = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
      r_rdy  = ($urandom_range(0, 9) < 4);
      model_step(r_sv, r_code, r_rdy);
      cyc(r_sv, r_code, r_rdy);
      model_check(n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_decoder.md
Name: ps2_ascii_decoder

Overview:
- Stateful successor to the combinational scan-code lookup.
- Consumes PS/2 Set-2 scan-code bytes from the PS/2 receiver as single-cycle strobes.
- Tracks make/break/extended prefixes plus Shift and Caps Lock state, and produces upper/lower-case letters, shifted digit symbols, space, enter and backspace.
- Decoded characters go into a parametrised first-word-fall-through FIFO with a valid/ready interface toward the processor's keyboard I/O port.

Parameters:
- FIFO_DEPTH, 4, number of buffered ASCII characters; power of two, ≥2.
- CASE_MODE, 0, 0 = letter case from Shift XOR Caps; 1 = letters always uppercase (legacy behaviour).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- scan_code  input  8  scan-code byte; qualified by scan_valid.
- scan_valid  input  1  one-cycle strobe: scan_code is valid this cycle.
- ascii_code  output  8  FIFO head character; 8'h00 when empty.
- ascii_valid  output  1  FIFO non-empty.
- ascii_ready  input  1  consumer accepts the head when ascii_valid is high.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored characters.
- overflow  output  1  one-cycle pulse: a decoded character was dropped because the FIFO was full.
- caps_lock  output  1  current Caps Lock state (drives the keyboard LED logic).
- shift_active  output  1  left OR right Shift currently held.

Behaviour:
Reset
- Reset is asynchronous and active-low: clock is clk, reset is rst_n.
- While rst_n is low: FSM = IDLE, FIFO empty, fifo_count = 0, ascii_valid = 0, ascii_code = 0, overflow = 0, caps_lock = 0, shift_active = 0, caps_held = 0.
- Reset mid-sequence (e.g. after F0) discards the prefix and any buffered characters.

Prefix FSM (advances only on scan_valid)
- IDLE:
  - F0 -> BRK.
  - E0 -> EXT.
  - 12 or 59 -> set left or right shift.
  - 58 with caps_held = 0 -> toggle caps_lock and set caps_held.
  - 58 with caps_held = 1 -> ignored (typematic repeat).
  - Mapped code -> push its character.
  - Any other code -> ignored.
- BRK:
  - 12 or 59 -> clear that shift.
  - 58 -> clear caps_held.
  - Any other code -> no action.
  - Always returns to IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - 5A (keypad Enter) -> push 8'h0D, go to IDLE.
  - Any other code -> ignored, go to IDLE.
- EXT_BRK: any code -> IDLE, no action.

Character map (Set 2)
- Digits: 45,16,1E,26,25,2E,36,3D,3E,46 -> "0".."9".
- Shifted digits -> ")!@#$%^&*(" respectively.
- Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
- Letter case:
  - Uppercase (41-5A) when CASE_MODE = 1 or (shift_active XOR caps_lock).
  - Otherwise lowercase (61-7A).
- 29 -> 20 (space); 5A -> 0D (enter); 66 -> 08 (backspace). These are unaffected by Shift.
- Shift state used for a character is the value registered before the current byte.

FIFO
- Push is decided combinationally from scan_code in the strobe cycle and written at that clock edge.
- Into an empty FIFO, ascii_valid and ascii_code appear the following cycle (1-cycle latency).
- Pop occurs on a clock edge where ascii_valid and ascii_ready are both high. The next entry, or 00 with ascii_valid low, is presented the cycle after.
- Push and pop in the same cycle: both occur and fifo_count is unchanged. This holds even when full, so no overflow.
- Push while full without a pop: character dropped, overflow pulses high for one cycle, state tracking still updates.
- Read and write pointers wrap modulo FIFO_DEPTH.
- ascii_ready while empty: no effect.
- Back-to-back scan_valid strobes on consecutive cycles are supported.

Test Plan:
1. Reset, then strobe 1C -> ascii_code = 61 ('a'), ascii_valid = 1 one cycle later, fifo_count = 1. Then F0,1C -> no further push.
2. Strobe 12, 1C, F0, 12, 1C -> FIFO holds 41 then 61. Strobe 12, 16 -> 21 ('!'). Strobe 58 -> caps_lock = 1; then 1C -> 41; then 12, 1C -> 61.
3. Caps typematic: 58, 58, 58, F0, 58 -> caps_lock toggles once (ends at 1). A second 58 then toggles it back to 0.
4. E0, 5A -> 0D pushed. E0, F0, 5A -> nothing pushed, FSM back in IDLE. Next 29 -> 20.
5. FIFO_DEPTH = 4 with ascii_ready = 0: push 5 characters -> fifo_count = 4, overflow pulses exactly once, and the head is still the first character. Raise ascii_ready while pushing -> count holds at 4, no overflow, characters drain in order across pointer wrap.
6. Assert rst_n low after F0 with 2 entries buffered -> ascii_valid = 0, count = 0, caps_lock = 0. After release, 1C -> 61 is pushed (the F0 prefix is forgotten).
